// File: rtl/key_ctrl_pkg.sv
// Shared FSM state type and default timing constants for the key conditioner.
package key_ctrl_pkg;

   typedef enum logic [1:0] {
      KS_IDLE,
      KS_PRESS_CNT,
      KS_HELD,
      KS_RELEASE_CNT
   } key_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int unsigned DEF_LONG_CYCLES     = 50000000;

endpackage

// File: rtl/key_ctrl_debounce.sv
// One raw button: 2-flop synchroniser, debounce FSM with a shared saturating
// counter, one-cycle press strobe and optional long-press strobe.
module key_debounce
   import key_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter logic        KEY_ACTIVE      = 1'b0,
   parameter bit          LONG_EN         = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press_pulse,
   output logic long_pulse
);

   localparam int CW = $clog2(LONG_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

   logic [1:0]    sync;
   logic          pressed;
   key_state_t    state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= {2{~KEY_ACTIVE}};
      else        sync <= {sync[0], key};
   end

   assign pressed = (sync[1] == KEY_ACTIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= KS_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            KS_IDLE: begin
               cnt <= '0;
               if (pressed) state <= KS_PRESS_CNT;
            end
            KS_PRESS_CNT: begin
               if (!pressed) begin
                  state <= KS_IDLE;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state <= KS_HELD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            KS_HELD: begin
               if (!pressed) begin
                  state <= KS_RELEASE_CNT;
                  cnt   <= '0;
               end else if (LONG_EN && cnt != LONG_SAT) begin
                  // parks at LONG_CYCLES so the long strobe cannot repeat
                  cnt <= cnt + 1'b1;
               end
            end
            KS_RELEASE_CNT: begin
               if (pressed) begin
                  state <= KS_HELD;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state <= KS_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= KS_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Decoded from flops only; high during the last stable cycle before HELD.
   assign press_pulse = (state == KS_PRESS_CNT) && pressed && (cnt == DB_LAST);
   assign long_pulse  = LONG_EN && (state == KS_HELD) && pressed && (cnt == LONG_LAST);

endmodule

// File: rtl/key_ctrl.sv
// Two-button conditioner for the LED stage: debounced direction/polarity toggles.
// Define KEY_LONGPRESS_EN to make a long key_pol hold restore both levels to defaults.
module key_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter logic        KEY_ACTIVE      = 1'b0,
   parameter logic        SW_INIT         = 1'b1,
   parameter logic        CHANGE_INIT     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_dir,
   input  logic key_pol,
   output logic change,
   output logic sw,
   output logic dir_pulse,
   output logic pol_pulse,
   output logic long_pulse
);

`ifdef KEY_LONGPRESS_EN
   localparam bit POL_LONG_EN = 1'b1;
`else
   localparam bit POL_LONG_EN = 1'b0;
`endif

   logic [1:0] rst_sync;
   logic       rst_n_i;
   logic       dir_long;
   logic       pol_long;

   // Asynchronous assert, release aligned to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n_i = rst_sync[1];

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .KEY_ACTIVE      (KEY_ACTIVE),
      .LONG_EN         (1'b0)
   ) u_dir (
      .clk         (clk),
      .rst_n       (rst_n_i),
      .key         (key_dir),
      .press_pulse (dir_pulse),
      .long_pulse  (dir_long)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .KEY_ACTIVE      (KEY_ACTIVE),
      .LONG_EN         (POL_LONG_EN)
   ) u_pol (
      .clk         (clk),
      .rst_n       (rst_n_i),
      .key         (key_pol),
      .press_pulse (pol_pulse),
      .long_pulse  (pol_long)
   );

   // dir_long is constant 0; only key_pol has a long-press function.
   assign long_pulse = pol_long | dir_long;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         change <= CHANGE_INIT;
         sw     <= SW_INIT;
      end else if (long_pulse) begin
         change <= CHANGE_INIT;
         sw     <= SW_INIT;
      end else begin
         change <= change ^ dir_pulse;
         sw     <= sw ^ pol_pulse;
      end
   end

endmodule
